// File: rtl/fetch_if.sv
// Fetch-stage bus bundle: instruction-memory port, redirect/stall inputs and
// the IF/ID payload driven by fetch_unit.
//
// Handshake: the memory side sees a request whenever imem_req=1 and answers
// for the current imem_addr by raising imem_ready with imem_rdata in the same
// cycle, after 1..N cycles. The downstream side consumes instr_out and
// pc_plus2_out when valid_out=1. It holds them by raising stall, which keeps
// the payload frozen for that cycle.
interface fetch_if;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_ready;
  logic [15:0] instr_out;
  logic [15:0] pc_plus2_out;
  logic        valid_out;
  logic        halted;

  modport master (
    input  stall, branch_taken, branch_target, imem_rdata, imem_ready,
    output imem_req, imem_addr, instr_out, pc_plus2_out, valid_out, halted
  );

  modport slave (
    output stall, branch_taken, branch_target, imem_rdata, imem_ready,
    input  imem_req, imem_addr, instr_out, pc_plus2_out, valid_out, halted
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: walks the PC through instruction memory, registers
// the fetched word for the IF/ID stage, and handles redirects, stalls and HLT.
// Optional macro FETCH_SKID_EN adds a one-entry skid buffer. The buffer keeps
// a response that arrives during a stall, so the unit does not re-request it.
module fetch_unit (
  input  logic       clk,
  input  logic       rst,
  fetch_if.master    bus,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2,
    S_HALT = 2'd3
  } state_t;

  state_t      state;
  logic [15:0] pc;
  logic [15:0] instr_q;
  logic [15:0] pc_plus2_q;
  logic        valid_q;
  logic        halted_q;
`ifdef FETCH_SKID_EN
  logic [15:0] skid_data;
  logic        skid_full;
`endif

  function automatic logic is_hlt(input logic [15:0] word);
    return word[15:12] == 4'hF;
  endfunction

  // Fetch FSM and all payload registers; redirect outranks everything but reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      pc         <= 16'h0000;
      instr_q    <= 16'h0000;
      pc_plus2_q <= 16'h0000;
      valid_q    <= 1'b0;
      halted_q   <= 1'b0;
`ifdef FETCH_SKID_EN
      skid_data  <= 16'h0000;
      skid_full  <= 1'b0;
`endif
    end else if (bus.branch_taken) begin
      // Same-cycle memory data belongs to the old path and is dropped.
      pc       <= bus.branch_target & 16'hFFFE;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      state    <= S_REQ;
`ifdef FETCH_SKID_EN
      skid_full <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: state <= S_REQ;

        S_REQ: begin
          if (bus.imem_ready && !bus.stall) begin
            instr_q    <= bus.imem_rdata;
            pc_plus2_q <= pc + 16'd2;
            valid_q    <= 1'b1;
            pc         <= pc + 16'd2;
            if (is_hlt(bus.imem_rdata)) begin
              state    <= S_HALT;
              halted_q <= 1'b1;
            end
          end else if (bus.imem_ready) begin
`ifdef FETCH_SKID_EN
            // Park the word; pc already points past it so HOLD never refetches.
            skid_data <= bus.imem_rdata;
            skid_full <= 1'b1;
            pc        <= pc + 16'd2;
            state     <= S_HOLD;
`endif
            // Without the skid buffer the word is dropped and pc is re-requested.
          end else if (!bus.stall) begin
            valid_q <= 1'b0;
          end
        end

        S_HOLD: begin
`ifdef FETCH_SKID_EN
          if (!bus.stall && skid_full) begin
            instr_q    <= skid_data;
            pc_plus2_q <= pc;
            valid_q    <= 1'b1;
            skid_full  <= 1'b0;
            if (is_hlt(skid_data)) begin
              state    <= S_HALT;
              halted_q <= 1'b1;
            end else begin
              state <= S_REQ;
            end
          end
`else
          state <= S_REQ;
`endif
        end

        S_HALT: begin
          if (!bus.stall) valid_q <= 1'b0;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.imem_req     = (state == S_REQ);
  assign bus.imem_addr    = pc;
  assign bus.instr_out    = instr_q;
  assign bus.pc_plus2_out = pc_plus2_q;
  assign bus.valid_out    = valid_q;
  assign bus.halted       = halted_q;
  assign state_dbg        = state;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a latency-programmable memory model
// and an in-order scoreboard of fetched (instr, pc+2) pairs.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst;
  logic [1:0] state_dbg;
  fetch_if bus();

  fetch_unit dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  // Memory contents: the top nibble is never F except at 0x0010 when HLT is armed.
  logic hlt_en = 1'b0;
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (hlt_en && a == 16'h0010) return 16'hF000;
    return {1'b0, a[3:1] + 3'd1, a[15:4]};
  endfunction

  // Memory model: ready after mem_lat consecutive request cycles on one address.
  int unsigned mem_lat = 1;
  int unsigned mem_cnt = 0;
  logic        prev_req = 1'b0;
  logic [15:0] prev_addr = 16'h0000;
  logic        same_addr;
  assign same_addr      = prev_req && (prev_addr == bus.imem_addr);
  assign bus.imem_rdata = mem_word(bus.imem_addr);
  assign bus.imem_ready = bus.imem_req &&
                          (((same_addr ? mem_cnt : 32'd0) + 32'd1) >= mem_lat);

  always @(posedge clk) begin
    prev_req  <= bus.imem_req;
    prev_addr <= bus.imem_addr;
    if (bus.imem_req && !bus.imem_ready) mem_cnt <= (same_addr ? mem_cnt : 32'd0) + 32'd1;
    else mem_cnt <= 0;
  end

  // Record the inputs seen by each active edge.
  logic e_stall, e_br, e_rst;
  always @(posedge clk) begin
    e_stall <= bus.stall;
    e_br    <= bus.branch_taken;
    e_rst   <= rst;
  end

  // A load happened at the last edge if it was unstalled, unredirected and valid rose/stayed.
  always @(negedge clk) begin
    if (e_rst === 1'b1 && e_stall === 1'b0 && e_br === 1'b0 && bus.valid_out === 1'b1) begin
      n_vec++;
      assert (exp_q.size() > 0) else begin
        n_err++;
        $error("FAIL unexpected_instr observed=%h/%h expected=none",
               bus.instr_out, bus.pc_plus2_out);
      end
      if (exp_q.size() > 0) begin
        logic [31:0] e;
        e = exp_q.pop_front();
        n_vec++;
        assert ({bus.instr_out, bus.pc_plus2_out} === e) else begin
          n_err++;
          $error("FAIL scoreboard observed=%h expected=%h",
                 {bus.instr_out, bus.pc_plus2_out}, e);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push_run(input logic [15:0] start, input int n);
    for (int i = 0; i < n; i++) begin
      logic [15:0] a;
      a = start + 16'(2 * i);
      exp_q.push_back({mem_word(a), a + 16'd2});
    end
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check(tag, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic redirect(input logic [15:0] tgt, input logic stall_v);
    bus.branch_taken  = 1'b1;
    bus.branch_target = tgt;
    bus.stall         = stall_v;
    tick();
    check("redir_addr", bus.imem_addr, tgt & 16'hFFFE);
    check("redir_valid", bus.valid_out, 1'b0);
    check("redir_halted", bus.halted, 1'b0);
    check("redir_req", bus.imem_req, 1'b1);
    bus.branch_taken = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset overrides an active redirect and stall.
    rst = 1'b0;
    bus.stall = 1'b1;
    bus.branch_taken = 1'b1;
    bus.branch_target = 16'h0100;
    repeat (3) tick();
    check("rst_req", bus.imem_req, 1'b0);
    check("rst_addr", bus.imem_addr, 16'h0000);
    check("rst_valid", bus.valid_out, 1'b0);
    check("rst_halted", bus.halted, 1'b0);
    check("rst_instr", bus.instr_out, 16'h0000);
    check("rst_pcp2", bus.pc_plus2_out, 16'h0000);
    check("rst_state", state_dbg, 2'd0);

    // 1-cycle memory from reset: IDLE, then REQ at 0, then a valid stream.
    mem_lat = 1;
    push_run(16'h0000, 4);
    rst = 1'b1;
    bus.stall = 1'b0;
    bus.branch_taken = 1'b0;
    check("c1_state", state_dbg, 2'd0);
    check("c1_req", bus.imem_req, 1'b0);
    tick();
    check("c2_req", bus.imem_req, 1'b1);
    check("c2_addr", bus.imem_addr, 16'h0000);
    check("c2_valid", bus.valid_out, 1'b0);
    tick();
    check("c3_valid", bus.valid_out, 1'b1);
    check("c3_pcp2", bus.pc_plus2_out, 16'h0002);
    wait_drain("drain_lat1", 10);

    // 3-cycle memory: valid pattern 1,0,0,1 with no address skipped.
    mem_lat = 3;
    push_run(16'h0100, 4);
    redirect(16'h0100, 1'b0);
    for (int i = 0; i < 10 && bus.valid_out !== 1'b1; i++) tick();
    check("lat3_v0", bus.valid_out, 1'b1);
    tick();
    check("lat3_v1", bus.valid_out, 1'b0);
    tick();
    check("lat3_v2", bus.valid_out, 1'b0);
    tick();
    check("lat3_v3", bus.valid_out, 1'b1);
    wait_drain("drain_lat3", 20);

    // Four-cycle stall while memory is ready: payload frozen.
    mem_lat = 1;
    push_run(16'h0200, 4);
    redirect(16'h0200, 1'b0);
    tick();
    check("pre_stall_instr", bus.instr_out, mem_word(16'h0200));
    bus.stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stall_instr", bus.instr_out, mem_word(16'h0200));
      check("stall_pcp2", bus.pc_plus2_out, 16'h0202);
      check("stall_valid", bus.valid_out, 1'b1);
`ifdef FETCH_SKID_EN
      check("stall_req_skid", bus.imem_req, 1'b0);
      check("stall_addr_skid", bus.imem_addr, 16'h0204);
`else
      check("stall_req", bus.imem_req, 1'b1);
      check("stall_addr", bus.imem_addr, 16'h0202);
`endif
    end
    bus.stall = 1'b0;
    tick();
    check("unstall_instr", bus.instr_out, mem_word(16'h0202));
    check("unstall_pcp2", bus.pc_plus2_out, 16'h0204);
    wait_drain("drain_stall", 10);

    // Redirect during stall to an odd target.
    check("pre_br_valid", bus.valid_out, 1'b1);
    push_run(16'h0040, 2);
    redirect(16'h0041, 1'b1);
    tick();
    check("br_stall_hold", bus.valid_out, 1'b0);
    bus.stall = 1'b0;
    wait_drain("drain_br", 10);

    // HLT at 0x0010 stops fetch; a redirect resumes it.
    hlt_en = 1'b1;
    push_run(16'h000C, 3);
    redirect(16'h000C, 1'b0);
    wait_drain("drain_hlt", 10);
    check("hlt_halted", bus.halted, 1'b1);
    check("hlt_instr", bus.instr_out, 16'hF000);
    check("hlt_pcp2", bus.pc_plus2_out, 16'h0012);
    check("hlt_req", bus.imem_req, 1'b0);
    check("hlt_valid", bus.valid_out, 1'b1);
    check("hlt_state", state_dbg, 2'd3);
    tick();
    check("hlt_valid_clr", bus.valid_out, 1'b0);
    check("hlt_addr", bus.imem_addr, 16'h0012);
    repeat (3) tick();
    check("hlt_stay", bus.halted, 1'b1);
    check("hlt_stay_req", bus.imem_req, 1'b0);
    hlt_en = 1'b0;
    push_run(16'h0000, 2);
    redirect(16'h0000, 1'b0);
    wait_drain("drain_resume", 10);

    // PC wraps from 0xFFFE to 0x0000.
    push_run(16'hFFFE, 2);
    redirect(16'hFFFE, 1'b0);
    tick();
    check("wrap_addr", bus.imem_addr, 16'h0000);
    check("wrap_pcp2", bus.pc_plus2_out, 16'h0000);
    wait_drain("drain_wrap", 10);

    // Reset in the middle of a pending request.
    mem_lat = 3;
    redirect(16'h0300, 1'b0);
    tick();
    rst = 1'b0;
    bus.branch_taken = 1'b1;
    bus.branch_target = 16'h0500;
    bus.stall = 1'b1;
    tick();
    check("mid_rst_req", bus.imem_req, 1'b0);
    check("mid_rst_addr", bus.imem_addr, 16'h0000);
    check("mid_rst_valid", bus.valid_out, 1'b0);
    check("mid_rst_instr", bus.instr_out, 16'h0000);
    check("mid_rst_pcp2", bus.pc_plus2_out, 16'h0000);
    check("mid_rst_state", state_dbg, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
